// File: rtl/seq_muldivmod.sv
// Multi-cycle radix-2 multiply/divide/modulo unit, signed or unsigned operands.
// Runs one iteration per cycle; results are presented behind a valid/ready output.
module seq_muldivmod #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken on a rising edge where in_valid && in_ready;
  // a result is taken on a rising edge where out_valid && out_ready. The
  // unit holds a single request, so in_ready is low from acceptance until
  // the result has been consumed.

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

  state_t               state;
  logic [1:0]           op_r;
  logic                 sgn_r;
  logic                 neg_r;
  logic                 bzero_r;
  logic [WIDTH-1:0]     cnt;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     bmag;
  logic [WIDTH:0]       rem;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;

  logic [WIDTH-1:0]     amag_in;
  logic [WIDTH-1:0]     bmag_in;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     diff;
  logic [WIDTH-1:0]     res_sel;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    amag_in = (sgn && A[WIDTH-1]) ? -A : A;
    bmag_in = (sgn && B[WIDTH-1]) ? -B : B;
    // Restoring step: bring in the next dividend bit, then try the subtract.
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, bmag};
    case (op_r)
      2'd0:    res_sel = bzero_r ? '1 : quo;
      2'd1:    res_sel = rem[WIDTH-1:0];
      default: res_sel = acc[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Y         <= '0;
      op_r      <= '0;
      sgn_r     <= 1'b0;
      neg_r     <= 1'b0;
      bzero_r   <= 1'b0;
      cnt       <= '0;
      quo       <= '0;
      bmag      <= '0;
      rem       <= '0;
      acc       <= '0;
      mcand     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r    <= op;
            sgn_r   <= sgn;
            neg_r   <= (op == 2'd1) ? A[WIDTH-1] : (A[WIDTH-1] ^ B[WIDTH-1]);
            bzero_r <= (B == '0);
            quo     <= amag_in;
            bmag    <= bmag_in;
            rem     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, amag_in};
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (op_r[1]) begin
            if (bmag[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            bmag  <= bmag >> 1;
          end else if (!diff[WIDTH+1]) begin
            rem <= diff[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero quotient stays all ones regardless of sign.
          Y         <= (sgn_r && neg_r && !(op_r == 2'd0 && bzero_r)) ? -res_sel : res_sel;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldivmod.sv
// Self-checking bench for seq_muldivmod: directed vector table, backpressure,
// mid-operation reset and a randomised scoreboard sweep.
module tb_seq_muldivmod;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   op;
  logic         sgn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic [1:0]   dbg_state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[16];

  seq_muldivmod #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .sgn(sgn), .out_valid(out_valid),
    .out_ready(out_ready), .Y(Y), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] o, input logic s);
    int sa, sb, r;
    if (o[1]) return W'(int'(a) * int'(b));
    if (b == 0) return (o == 2'd0) ? {W{1'b1}} : a;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    r  = (o == 2'd0) ? sa / sb : sa % sb;
    return W'(r);
  endfunction

  // driver: issue one request, wait for its result, consume it
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                        input logic s, output logic [W-1:0] y, output int lat);
    int t;
    @(negedge clk);
    A = a; B = b; op = o; sgn = s; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom_range(0, 255); B = $urandom_range(0, 255);
    op = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    y = Y;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] y, y_hold;
    int lat, t;
    bit seen;

    vecs[0]  = '{8'd200, 8'd8,  2'd0, 1'b0, 8'h19};
    vecs[1]  = '{8'd200, 8'd8,  2'd1, 1'b0, 8'h00};
    vecs[2]  = '{8'hF9,  8'd2,  2'd0, 1'b1, 8'hFD};
    vecs[3]  = '{8'hF9,  8'd2,  2'd1, 1'b1, 8'hFF};
    vecs[4]  = '{8'h80,  8'hFF, 2'd0, 1'b1, 8'h80};
    vecs[5]  = '{8'h80,  8'hFF, 2'd1, 1'b1, 8'h00};
    vecs[6]  = '{8'h5A,  8'h00, 2'd0, 1'b0, 8'hFF};
    vecs[7]  = '{8'h5A,  8'h00, 2'd1, 1'b0, 8'h5A};
    vecs[8]  = '{8'h5A,  8'h00, 2'd0, 1'b1, 8'hFF};
    vecs[9]  = '{8'h5A,  8'h00, 2'd1, 1'b1, 8'h5A};
    vecs[10] = '{8'hFD,  8'hF8, 2'd2, 1'b1, 8'h18};
    vecs[11] = '{8'd200, 8'd2,  2'd3, 1'b0, 8'h90};
    vecs[12] = '{8'hF9,  8'd2,  2'd0, 1'b0, 8'h7C};
    vecs[13] = '{8'hF9,  8'd2,  2'd1, 1'b0, 8'h01};
    vecs[14] = '{8'hFD,  8'h02, 2'd2, 1'b1, 8'hFA};
    vecs[15] = '{8'hFA,  8'h00, 2'd0, 1'b1, 8'hFF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; op = '0; sgn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_y", int'(Y), 0);
    check("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn, y, lat);
      check($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_idle_after", i), int'(in_ready && !out_valid), 1);
    end

    // backpressure: result held while a second request waits
    @(negedge clk);
    A = 8'd100; B = 8'd9; op = 2'd0; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 8'd77; B = 8'd5; op = 2'd1;
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); t++; @(negedge clk); end
    check("bp_first_lat", t, LAT);
    y_hold = Y;
    check("bp_first_y", int'(y_hold), 11);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d", k),
            int'({out_valid, in_ready, (Y == y_hold)}), int'(3'b101));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", int'({out_valid, in_ready}), int'(2'b01));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_pending_accepted", int'(in_ready), 0);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); t++; @(negedge clk); end
    check("bp_second_lat", t, LAT);
    check("bp_second_y", int'(Y), 2);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // reset during the 4th CALC cycle discards the operation
    A = 8'd250; B = 8'd3; op = 2'd0; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_y", int'(Y), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    seen = 1'b0;
    repeat (15) begin @(posedge clk); @(negedge clk); if (out_valid) seen = 1'b1; end
    check("rst_mid_no_result", int'(seen), 0);
    do_req(8'd100, 8'd7, 2'd0, 1'b0, y, lat);
    check("rst_fresh_y", int'(y), 14);
    check("rst_fresh_lat", lat, LAT);

    // random sweep against the reference operators
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      logic         rs;
      ra = W'($urandom_range(0, 255));
      rb = (i % 10 == 0) ? '0 : W'($urandom_range(0, 255));
      ro = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, ro, rs));
      do_req(ra, rb, ro, rs, y, lat);
      check($sformatf("rand%0d_%0h_%0h_op%0d_s%0d", i, ra, rb, ro, rs), int'(y), int'(exp_q.pop_front()));
      check($sformatf("rand%0d_lat", i), lat, LAT);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_muldivmod.md
# seq_muldivmod

Multi-cycle sequential multiply/divide/modulo unit for 8-bit operands with a variable divisor/multiplier, signed and unsigned. It sits directly downstream of the constant-operand mul/div/mod stage. It reproduces that stage's `*`, `/` and `%` semantics when the constant becomes a runtime operand. One radix-2 iteration runs per cycle. A valid/ready handshake is used on both sides.

## Interface
- `WIDTH`, default 8: operand and result width; latency scales with it.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit idle; request accepted on `in_valid && in_ready`.
- `A`  in  WIDTH  dividend / multiplicand.
- `B`  in  WIDTH  divisor / multiplier.
- `op`  in  2  0 = `A/B`, 1 = `A%B`, 2 = `A*B`, 3 = `A*B` (alias of 2).
- `sgn`  in  1  1 = both operands two's-complement signed; 0 = unsigned.
- `out_valid`  out  1  `Y` holds a result.
- `out_ready`  in  1  consumer takes result on `out_valid && out_ready`.
- `Y`  out  WIDTH  result, truncated to WIDTH bits.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `in_ready`=1, combinational from state.
  - On handshake, latch `op` and `sgn`.
  - Latch |A| and |B|: magnitudes when `sgn`=1, raw values otherwise.
  - Record result sign: `A[MSB]^B[MSB]` for div/mul, `A[MSB]` for mod.
  - Clear the WIDTH-bit iteration counter and go to CALC.
- CALC, exactly WIDTH cycles:
  - Div/mod: restoring division, MSB first. Partial remainder is WIDTH+1 bits; one quotient bit per cycle.
  - Mul: shift-add, LSB first. 2·WIDTH accumulator; only the low WIDTH bits are used.
  - When the counter reaches WIDTH−1, go to FIX.
- FIX, 1 cycle:
  - Select quotient, remainder or low product.
  - Negate it if `sgn`=1 and the recorded sign is 1.
  - Register the result into `Y`, set `out_valid`, go to DONE.
- DONE:
  - `Y` and `out_valid` hold stable until `out_ready`=1.
  - On that edge, clear `out_valid` and go to IDLE.
  - `in_ready`=0 throughout DONE; no overlap of requests.
- Signed rules, matching Verilog:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - `-128 / -1` = 8'h80 (wraps); `-128 % -1` = 0.
- Divide by zero (B=0), decided behaviour for both signed and unsigned:
  - `/` → all ones (8'hFF).
  - `%` → A unchanged.
  - Latency is the same as any other request; no early exit.
- Multiply: the low WIDTH bits are identical for signed and unsigned, but the FIX negation path is still exercised when `sgn`=1.
- Inputs `A`, `B`, `op`, `sgn` are ignored outside the accepting cycle.

## Timing
- Reset values: `out_valid`=0, `Y`=0, state IDLE, so `in_ready`=1 in the first cycle after reset release.
- Latency: request accepted at edge N; `out_valid` rises after edge N+WIDTH+1 (N+9 for WIDTH=8). Every op and operand value takes exactly this latency.
- Earliest next acceptance: the cycle after the output handshake edge. Throughput is at best one result per WIDTH+3 cycles.
- `rst` asserted in any state, including mid-CALC or DONE with `out_valid`=1:
  - Next edge forces IDLE, `out_valid`=0, `Y`=0.
  - The in-flight result is discarded and never presented.
- `rst` has priority over a simultaneous `in_valid` or `out_ready`.
- `in_valid` while not in IDLE is not accepted; the source must hold the request.

## Test plan
- Unsigned: A=200, B=8, sgn=0.
  - op=0 → Y=25 (8'h19); `out_valid` exactly 9 edges after acceptance.
  - op=1 → Y=0.
- Signed: A=8'hF9 (−7), B=2, sgn=1.
  - op=0 → Y=8'hFD (−3).
  - op=1 → Y=8'hFF (−1).
  - A=8'h80, B=8'hFF → Y=8'h80 (op 0) and Y=0 (op 1).
- Divide by zero: A=8'h5A, B=0, both `sgn` values.
  - op=0 → Y=8'hFF.
  - op=1 → Y=8'h5A.
  - Latency unchanged.
- Multiply:
  - sgn=1, A=8'hFD, B=8'hF8 → Y=8'h18.
  - sgn=0, A=200, B=2 → Y=8'h90.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE → `Y` and `out_valid` stable, `in_ready`=0, pending `in_valid` not accepted.
  - On release, the pending request is accepted on the following edge.
- Reset mid-operation:
  - Assert `rst` for 1 cycle at the 4th CALC cycle → next cycle `out_valid`=0, `Y`=0, `in_ready`=1; no result appears.
  - A fresh request (100/7, unsigned) then returns Y=14 with nominal latency.
- Random sweep: a scoreboard compares every (A, B, op, sgn) against the Verilog operators, with the decided divide-by-zero values substituted where B=0.
